// File: rtl/factorial_inverse_if.sv
// Handshake and result bundle for the factorial inverse block.
// The requester drives start/val_in; the block returns busy, done and the result.
interface factorial_inverse_if #(
  parameter int WIDTH = 32,
  parameter int NW    = 4
);
  logic             start;
  logic [WIDTH-1:0] val_in;
  logic             busy;
  logic             done;
  logic [NW-1:0]    n_out;
  logic [WIDTH-1:0] fact_out;
  logic             exact;

  modport master (
    output start, val_in,
    input  busy, done, n_out, fact_out, exact
  );

  modport slave (
    input  start, val_in,
    output busy, done, n_out, fact_out, exact
  );
endinterface

// File: rtl/factorial_inverse.sv
// Iterative inverse factorial: finds the largest n with n! <= V, n! itself and
// whether V is exactly a factorial. One multiply per cycle.
//
//   state | meaning
//   IDLE  | waiting for start; last result held on the outputs
//   CALC  | one multiply-and-compare step per cycle
module factorial_inverse #(
  parameter int WIDTH = 32,
  parameter int NW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  factorial_inverse_if.slave    bus
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [NW-1:0] N_MAX = {NW{1'b1}};

  state_t             state, state_nx;
  logic [WIDTH-1:0]   val_r, val_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [NW-1:0]      n, n_nx;
  logic               done_r, done_nx;
  logic [NW-1:0]      n_res, n_res_nx;
  logic [WIDTH-1:0]   fact_r, fact_nx;
  logic               exact_r, exact_nx;

  logic [NW:0]        n_plus;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] val_wide;

  // Full double-width product so the compare never sees a wrapped value.
  assign n_plus   = {1'b0, n} + {{NW{1'b0}}, 1'b1};
  assign prod     = {{WIDTH{1'b0}}, acc} * {{(2*WIDTH-NW-1){1'b0}}, n_plus};
  assign val_wide = {{WIDTH{1'b0}}, val_r};

  // Next-state, datapath and result computation.
  always_comb begin
    state_nx = state;
    val_nx   = val_r;
    acc_nx   = acc;
    n_nx     = n;
    done_nx  = 1'b0;
    n_res_nx = n_res;
    fact_nx  = fact_r;
    exact_nx = exact_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          val_nx   = bus.val_in;
          acc_nx   = {{(WIDTH-1){1'b0}}, 1'b1};
          n_nx     = {{(NW-1){1'b0}}, 1'b1};
          state_nx = CALC;
        end
      end
      CALC: begin
        if (acc > val_r) begin
          // Only reachable for V=0: report 0! = 1, never exact.
          n_res_nx = '0;
          fact_nx  = {{(WIDTH-1){1'b0}}, 1'b1};
          exact_nx = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if ((prod <= val_wide) && (n != N_MAX)) begin
          acc_nx = prod[WIDTH-1:0];
          n_nx   = n_plus[NW-1:0];
        end else begin
          n_res_nx = n;
          fact_nx  = acc;
          exact_nx = (acc == val_r);
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and result registers; reset aborts any calculation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      val_r   <= '0;
      acc     <= '0;
      n       <= '0;
      done_r  <= 1'b0;
      n_res   <= '0;
      fact_r  <= '0;
      exact_r <= 1'b0;
    end else begin
      state   <= state_nx;
      val_r   <= val_nx;
      acc     <= acc_nx;
      n       <= n_nx;
      done_r  <= done_nx;
      n_res   <= n_res_nx;
      fact_r  <= fact_nx;
      exact_r <= exact_nx;
    end
  end

  assign bus.busy     = (state == CALC);
  assign bus.done     = done_r;
  assign bus.n_out    = n_res;
  assign bus.fact_out = fact_r;
  assign bus.exact    = exact_r;

endmodule
